// File: rtl/capture_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | capture_ctrl : periodic windowed capture of three Grey ring counters with   |
// |                valid/ready output. Optional macro: CAPTURE_DELTA_EN (deltas)|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module capture_ctrl #(
  parameter int pPWIDTH = 16,
  parameter int pNWIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [pPWIDTH-1:0] i_period,
  input  logic [pNWIDTH-1:0] i_nwin,
  input  logic [4:0]         i_100,
  input  logic [4:0]         i_010,
  input  logic [4:0]         i_001,
  output logic [4:0]         o_100,
  output logic [4:0]         o_010,
  output logic [4:0]         o_001,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [pNWIDTH-1:0] o_seq,
  output logic               o_busy,
  output logic               o_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state_q;
  logic [pPWIDTH-1:0] period_q;
  logic [pPWIDTH-1:0] cnt_q;
  logic [pNWIDTH-1:0] nwin_q;
  logic [pNWIDTH-1:0] win_q;
  logic [pNWIDTH-1:0] nseq_q;
  logic [4:0]         d100_q, d010_q, d001_q;
  logic               valid_q;
  logic [pNWIDTH-1:0] seq_q;
  logic               ovf_q;

  logic               strobe;
  logic               load;
  logic               last;
  logic [4:0]         cap100_d, cap010_d, cap001_d;

`ifdef CAPTURE_DELTA_EN
  logic [4:0]         p100_q, p010_q, p001_q;
  logic [4:0]         cur100, cur010, cur001;

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int k = 3; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction
`endif

  always_comb begin
    strobe = (state_q == RUN) && (cnt_q == period_q) && !i_stop;
    // A strobe loads only if the output slot is free or being emptied now
    load   = strobe && (!valid_q || i_ready);
    last   = (nwin_q != '0) && (win_q == nwin_q - pNWIDTH'(1));
`ifdef CAPTURE_DELTA_EN
    cur100   = g2b(i_100);
    cur010   = g2b(i_010);
    cur001   = g2b(i_001);
    cap100_d = cur100 - p100_q;
    cap010_d = cur010 - p010_q;
    cap001_d = cur001 - p001_q;
`else
    cap100_d = i_100;
    cap010_d = i_010;
    cap001_d = i_001;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      nwin_q   <= '0;
      win_q    <= '0;
      nseq_q   <= '0;
      d100_q   <= '0;
      d010_q   <= '0;
      d001_q   <= '0;
      valid_q  <= 1'b0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef CAPTURE_DELTA_EN
      p100_q   <= '0;
      p010_q   <= '0;
      p001_q   <= '0;
`endif
    end else begin
      if (valid_q && i_ready) valid_q <= 1'b0;
      if (load) begin
        d100_q  <= cap100_d;
        d010_q  <= cap010_d;
        d001_q  <= cap001_d;
        valid_q <= 1'b1;
        seq_q   <= nseq_q;
        nseq_q  <= nseq_q + pNWIDTH'(1);
      end
      case (state_q)
        IDLE: begin
          if (i_start) state_q <= ARM;
        end
        ARM: begin
          period_q <= i_period;
          nwin_q   <= i_nwin;
          cnt_q    <= '0;
          win_q    <= '0;
          nseq_q   <= '0;
          seq_q    <= '0;
          ovf_q    <= 1'b0;
`ifdef CAPTURE_DELTA_EN
          p100_q   <= g2b(i_100);
          p010_q   <= g2b(i_010);
          p001_q   <= g2b(i_001);
`endif
          state_q  <= RUN;
        end
        RUN: begin
          if (i_stop) begin
            state_q <= DRAIN;
          end else begin
            cnt_q <= (cnt_q == period_q) ? '0 : cnt_q + pPWIDTH'(1);
            if (strobe) begin
              win_q <= win_q + pNWIDTH'(1);
              if (!load) ovf_q <= 1'b1;
`ifdef CAPTURE_DELTA_EN
              p100_q <= cur100;
              p010_q <= cur010;
              p001_q <= cur001;
`endif
              if (last) state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!valid_q || i_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_100   = d100_q;
  assign o_010   = d010_q;
  assign o_001   = d001_q;
  assign o_valid = valid_q;
  assign o_seq   = seq_q;
  assign o_ovf   = ovf_q;
  assign o_busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// Scoreboard bench for capture_ctrl: stimulus pushes expected samples, a
// negedge monitor pops and compares on every output handshake.
module tb_capture_ctrl;

`ifdef CAPTURE_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_stop, i_ready;
  logic [15:0] i_period;
  logic [7:0]  i_nwin;
  logic [4:0]  i_100, i_010, i_001;
  logic [4:0]  o_100, o_010, o_001;
  logic        o_valid, o_busy, o_ovf;
  logic [7:0]  o_seq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [14:0] d;
    logic [7:0]  seq;
  } exp_t;
  exp_t q[$];

  capture_ctrl #(.pPWIDTH(16), .pNWIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_period(i_period), .i_nwin(i_nwin),
    .i_100(i_100), .i_010(i_010), .i_001(i_001),
    .o_100(o_100), .o_010(o_010), .o_001(o_001),
    .o_valid(o_valid), .i_ready(i_ready), .o_seq(o_seq),
    .o_busy(o_busy), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int k = 3; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  // Expected output word for a strobe seeing cur, previous strobe/baseline prev
  function automatic logic [14:0] expv(input logic [14:0] cur, input logic [14:0] prev);
    if (DELTA)
      return {5'(g2b(cur[14:10]) - g2b(prev[14:10])),
              5'(g2b(cur[9:5])   - g2b(prev[9:5])),
              5'(g2b(cur[4:0])   - g2b(prev[4:0]))};
    return cur;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [14:0] v);
    {i_100, i_010, i_001} = v;
  endtask

  task automatic push(input logic [14:0] cur, input logic [14:0] prev, input logic [7:0] seq);
    exp_t e;
    e.d   = expv(cur, prev);
    e.seq = seq;
    q.push_back(e);
  endtask

  // Leaves the bench one step into RUN cycle 0 (interval counter = 0)
  task automatic do_start(input logic [15:0] per, input logic [7:0] nw);
    i_start  = 1'b1;
    i_period = per;
    i_nwin   = nw;
    tick();
    i_start  = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_sample", {24'd0, o_seq}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sample_data", {17'd0, o_100, o_010, o_001}, {17'd0, e.d});
        chk("sample_seq", {24'd0, o_seq}, {24'd0, e.seq});
      end
    end
  end

  localparam logic [14:0] X1 = {5'h03, 5'h11, 5'h1E};
  localparam logic [14:0] S1 = {5'h0A, 5'h05, 5'h17};
  localparam logic [14:0] S2 = {5'h1C, 5'h02, 5'h09};
  localparam logic [14:0] S3 = {5'h06, 5'h1F, 5'h10};

  initial begin
    rst = 1'b1; i_start = 0; i_stop = 0; i_ready = 0;
    i_period = '0; i_nwin = '0; set_in('0);
    tick(); tick();
    chk("rst_valid", {31'd0, o_valid}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_ovf", {31'd0, o_ovf}, 0);
    chk("rst_data_seq", {9'd0, o_100, o_010, o_001, o_seq}, 0);
    rst = 1'b0;
    tick();

    // Period 3, two windows, always ready
    i_ready = 1'b1; set_in(X1);
    do_start(16'd3, 8'd2);
    tick(); tick(); tick();
    chk("t1_no_early_valid", {31'd0, o_valid}, 0);
    set_in(S1); push(S1, X1, 8'd0);
    tick();
    chk("t1_valid_after_strobe", {31'd0, o_valid}, 1);
    set_in(X1);
    tick(); tick(); tick();
    set_in(S2); push(S2, S1, 8'd1);
    tick();
    chk("t1_drain_busy", {31'd0, o_busy}, 1);
    chk("t1_drain_valid", {31'd0, o_valid}, 1);
    set_in(X1);
    tick();
    chk("t1_idle_busy", {31'd0, o_busy}, 0);
    chk("t1_idle_valid", {31'd0, o_valid}, 0);
    chk("t1_ovf", {31'd0, o_ovf}, 0);

    // Period 0, continuous, consumer stalled: overflow then stop
    i_ready = 1'b0; set_in(X1);
    do_start(16'd0, 8'd0);
    set_in(S1); push(S1, X1, 8'd0);
    tick();
    set_in(S2);
    tick(); tick();
    chk("t2_ovf", {31'd0, o_ovf}, 1);
    chk("t2_seq", {24'd0, o_seq}, 0);
    chk("t2_held_data", {17'd0, o_100, o_010, o_001}, {17'd0, expv(S1, X1)});
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("t2_drain_busy", {31'd0, o_busy}, 1);
    tick(); tick();
    chk("t2_drain_hold", {31'd0, o_busy & o_valid}, 1);
    i_ready = 1'b1;
    tick();
    chk("t2_idle_busy", {31'd0, o_busy}, 0);
    chk("t2_idle_valid", {31'd0, o_valid}, 0);
    chk("t2_ovf_held", {31'd0, o_ovf}, 1);

    // Stop coinciding with the first strobe
    i_ready = 1'b1;
    do_start(16'd1, 8'd0);
    tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("t3_no_valid", {31'd0, o_valid}, 0);
    chk("t3_drain_busy", {31'd0, o_busy}, 1);
    tick();
    chk("t3_idle_busy", {31'd0, o_busy}, 0);

    // Back-to-back: handshake and strobe in the same cycle
    i_ready = 1'b1; set_in(X1);
    do_start(16'd0, 8'd3);
    set_in(S1); push(S1, X1, 8'd0);
    tick();
    chk("t4_valid1", {31'd0, o_valid}, 1);
    set_in(S2); push(S2, S1, 8'd1);
    tick();
    chk("t4_valid2", {31'd0, o_valid}, 1);
    set_in(S3); push(S3, S2, 8'd2);
    tick();
    chk("t4_valid3", {31'd0, o_valid}, 1);
    chk("t4_drain_busy", {31'd0, o_busy}, 1);
    tick();
    chk("t4_idle", {30'd0, o_busy, o_valid}, 0);
    chk("t4_ovf_cleared", {31'd0, o_ovf}, 0);
    chk("t4_seq_held", {24'd0, o_seq}, 2);

    // Grey 00011 then 00000 on channel 100 from a zero baseline
    i_ready = 1'b1; set_in('0);
    do_start(16'd0, 8'd2);
    set_in({5'b00011, 5'd0, 5'd0}); push({5'b00011, 5'd0, 5'd0}, 15'd0, 8'd0);
    tick();
    chk("t6_o100_first", {27'd0, o_100}, DELTA ? 32'd2 : 32'd3);
    set_in('0); push(15'd0, {5'b00011, 5'd0, 5'd0}, 8'd1);
    tick();
    chk("t6_o100_second", {27'd0, o_100}, DELTA ? 32'd30 : 32'd0);
    tick();
    chk("t6_idle_busy", {31'd0, o_busy}, 0);

    // Asynchronous reset mid-run with a sample pending
    i_ready = 1'b0; set_in(X1);
    do_start(16'd0, 8'd0);
    set_in(S1);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", {31'd0, o_valid}, 0);
    chk("t5_async_busy", {31'd0, o_busy}, 0);
    chk("t5_async_ovf", {31'd0, o_ovf}, 0);
    chk("t5_async_data_seq", {9'd0, o_100, o_010, o_001, o_seq}, 0);
    tick();
    rst = 1'b0;
    tick();
    i_ready = 1'b1; set_in(X1);
    do_start(16'd0, 8'd1);
    set_in(S2); push(S2, X1, 8'd0);
    tick();
    chk("t5_restart_valid", {31'd0, o_valid}, 1);
    tick();
    chk("t5_restart_idle", {31'd0, o_busy}, 0);

    tick();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
